// File: rtl/addr_sequencer_pkg.sv
// Shared types and default widths for the readout address sequencer.
package addr_sequencer_pkg;

  localparam int unsigned DefAw = 8;
  localparam int unsigned DefPw = 8;

  typedef enum logic [0:0] {
    StIdle,
    StRun
  } state_e;

endpackage

// File: rtl/addr_sequencer.sv
// Walks first_addr..last_addr in steps of step, single-shot or wrapping, with hold/abort,
// done/aborted pulses and a pass counter.
module addr_sequencer
  import addr_sequencer_pkg::*;
#(
  parameter int unsigned AW = DefAw,
  parameter int unsigned PW = DefPw
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ss,
  input  logic          abort,
  input  logic          hold,
  input  logic          continuous,
  input  logic [AW-1:0] first_addr,
  input  logic [AW-1:0] last_addr,
  input  logic [AW-1:0] step,
  output logic [AW-1:0] addr,
  output logic          running,
  output logic          done,
  output logic          aborted,
  output logic [PW-1:0] pass_cnt
);

  state_e        state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [PW-1:0] pass_q, pass_d;
  logic          done_q, done_d;
  logic          aborted_q, aborted_d;
  logic          cont_q, cont_d;
  logic [AW-1:0] first_q, first_d;
  logic [AW-1:0] last_q, last_d;
  logic [AW-1:0] step_q, step_d;

  logic [AW:0]   nxt;
  logic          end_of_pass;

  // One extra bit so an overshoot past 2^AW-1 is still seen as beyond last_q.
  assign nxt         = {1'b0, addr_q} + {1'b0, step_q};
  assign end_of_pass = (addr_q >= last_q) || (nxt > {1'b0, last_q});

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    pass_d    = pass_q;
    done_d    = 1'b0;
    aborted_d = 1'b0;
    cont_d    = cont_q;
    first_d   = first_q;
    last_d    = last_q;
    step_d    = step_q;

    unique case (state_q)
      StIdle: begin
        if (ss && !abort) begin
          cont_d  = continuous;
          first_d = first_addr;
          last_d  = last_addr;
          step_d  = (step == '0) ? AW'(1) : step;
          addr_d  = first_addr;
          pass_d  = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        if (abort) begin
          aborted_d = 1'b1;
          state_d   = StIdle;
        end else if (hold) begin
          state_d = StRun;
        end else if (end_of_pass) begin
          pass_d = pass_q + PW'(1);
          if (cont_q) begin
            addr_d = first_q;
          end else begin
            done_d  = 1'b1;
            state_d = StIdle;
          end
        end else begin
          addr_d = nxt[AW-1:0];
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      addr_q    <= '0;
      pass_q    <= '0;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
      cont_q    <= 1'b0;
      first_q   <= '0;
      last_q    <= '0;
      step_q    <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      pass_q    <= pass_d;
      done_q    <= done_d;
      aborted_q <= aborted_d;
      cont_q    <= cont_d;
      first_q   <= first_d;
      last_q    <= last_d;
      step_q    <= step_d;
    end
  end

  assign addr     = addr_q;
  assign running  = (state_q == StRun);
  assign done     = done_q;
  assign aborted  = aborted_q;
  assign pass_cnt = pass_q;

endmodule
